// File: rtl/laststage_ctrl.sv
// laststage_ctrl: pairs a serial complex stream into even/odd operands for the final radix-2
// butterfly and tracks each pair through its enable-gated pipe. Optional: LASTSTAGE_CTRL_FRAMECHECK_EN.
module laststage_ctrl #(
  parameter int IWIDTH  = 16,
  parameter int OWIDTH  = IWIDTH + 1,
  parameter int LGSIZE  = 12,
  parameter int LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*IWIDTH-1:0]   s_data,
  input  logic                  s_first,
  output logic                  o_bf_ce,
  output logic                  o_bf_sync,
  output logic [2*IWIDTH-1:0]   o_bf_left,
  output logic [2*IWIDTH-1:0]   o_bf_right,
  input  logic [2*OWIDTH-1:0]   i_bf_left,
  input  logic [2*OWIDTH-1:0]   i_bf_right,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*OWIDTH-1:0]   m_left,
  output logic [2*OWIDTH-1:0]   m_right,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  o_err
);

  localparam int CW = LGSIZE - 1;
  localparam logic [CW-1:0] LAST_PAIR = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVEN  = 2'd1,
    S_ODD   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2*IWIDTH-1:0] r_even;
  logic                r_pair_pending;
  logic [CW-1:0]       r_pair_cnt;
  logic [LATENCY-1:0]  r_tag_v;
  logic [LATENCY-1:0]  r_tag_f;
  logic [LATENCY-1:0]  r_tag_l;
  logic                r_err;

  logic          w_accept;
  logic          w_pipe_busy;
  logic          w_bubble;
  logic          w_issue;
  logic          w_misalign;
  logic          w_pair_last;
  logic          w_load_even;
  logic          w_load_pair;
  logic          w_resync;
  logic [CW-1:0] w_pair_idx;

`ifdef LASTSTAGE_CTRL_FRAMECHECK_EN
  assign w_misalign = s_first;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_pipe_busy = |r_tag_v;
  assign w_bubble    = (r_state == S_FLUSH) && !r_pair_pending && w_pipe_busy;
  assign o_bf_ce     = m_ready && (r_pair_pending || w_bubble);
  assign w_issue     = o_bf_ce && r_pair_pending;
  assign o_bf_sync   = w_issue && (r_pair_cnt == {CW{1'b0}});
  assign s_ready     = (r_state != S_FLUSH) && (!r_pair_pending || o_bf_ce);
  assign w_accept    = s_valid && s_ready;

  // A pending pair at odd-accept time is being enabled now, so the new pair is one further on.
  assign w_pair_idx  = r_pair_cnt + {{(CW-1){1'b0}}, r_pair_pending};
  assign w_pair_last = (w_pair_idx == LAST_PAIR);

  assign m_valid = r_tag_v[LATENCY-1];
  assign m_first = r_tag_v[LATENCY-1] && r_tag_f[LATENCY-1];
  assign m_last  = r_tag_v[LATENCY-1] && r_tag_l[LATENCY-1];
  assign m_left  = i_bf_left;
  assign m_right = i_bf_right;
  assign o_err   = r_err;

  // Next-state and load decisions for the pairing FSM.
  always_comb begin
    w_next_state = r_state;
    w_load_even  = 1'b0;
    w_load_pair  = 1'b0;
    w_resync     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && s_first) begin
          w_load_even  = 1'b1;
          w_next_state = S_ODD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EVEN: begin
        if (w_accept) begin
          w_load_even  = 1'b1;
          w_resync     = w_misalign;
          w_next_state = S_ODD;
        end else begin
          w_next_state = S_EVEN;
        end
      end
      S_ODD: begin
        if (w_accept && w_misalign) begin
          w_load_even  = 1'b1;
          w_resync     = 1'b1;
          w_next_state = S_ODD;
        end else if (w_accept) begin
          w_load_pair  = 1'b1;
          w_next_state = w_pair_last ? S_FLUSH : S_EVEN;
        end else begin
          w_next_state = S_ODD;
        end
      end
      S_FLUSH: begin
        if (!r_pair_pending && !w_pipe_busy) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_FLUSH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, operand, pair counter and tag pipe registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_even         <= '0;
      o_bf_left      <= '0;
      o_bf_right     <= '0;
      r_pair_pending <= 1'b0;
      r_pair_cnt     <= '0;
      r_tag_v        <= '0;
      r_tag_f        <= '0;
      r_tag_l        <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_resync;

      if (w_load_even) begin
        r_even <= s_data;
      end

      if (w_load_pair) begin
        o_bf_left  <= r_even;
        o_bf_right <= s_data;
      end

      if (w_load_pair) begin
        r_pair_pending <= 1'b1;
      end else if (w_issue) begin
        r_pair_pending <= 1'b0;
      end

      if (w_resync) begin
        r_pair_cnt <= '0;
      end else if (w_issue) begin
        r_pair_cnt <= r_pair_cnt + CW'(1);
      end

      // Bubble enables shift in an empty tag; a delivered result without a shift is retired.
      if (o_bf_ce) begin
        r_tag_v <= {r_tag_v[LATENCY-2:0], r_pair_pending};
        r_tag_f <= {r_tag_f[LATENCY-2:0], r_pair_pending && (r_pair_cnt == {CW{1'b0}})};
        r_tag_l <= {r_tag_l[LATENCY-2:0], r_pair_pending && (r_pair_cnt == LAST_PAIR)};
      end else if (m_valid && m_ready) begin
        r_tag_v[LATENCY-1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_laststage_ctrl.sv
// Self-checking bench for laststage_ctrl: random sample frames against a pair-level scoreboard,
// with a behavioural 3-stage butterfly standing in for the arithmetic.
`timescale 1ns/1ps
module tb_laststage_ctrl;

  localparam int IW = 16;
  localparam int OW = IW + 1;
  localparam int LG = 12;
  localparam int NP = 1 << (LG - 1);

  typedef struct packed {
    logic [2*OW-1:0] l;
    logic [2*OW-1:0] r;
    logic            f;
    logic            la;
  } exp_t;

  logic            clk;
  logic            i_reset;
  logic            s_valid;
  logic            s_ready;
  logic [2*IW-1:0] s_data;
  logic            s_first;
  logic            o_bf_ce;
  logic            o_bf_sync;
  logic [2*IW-1:0] o_bf_left;
  logic [2*IW-1:0] o_bf_right;
  logic [2*OW-1:0] bl1, bl2, bl3;
  logic [2*OW-1:0] br1, br2, br3;
  logic            m_valid;
  logic            m_ready;
  logic [2*OW-1:0] m_left;
  logic [2*OW-1:0] m_right;
  logic            m_first;
  logic            m_last;
  logic            o_err;

  int   n_pass = 0;
  int   n_total = 0;
  int   ce_total = 0;
  int   sync_total = 0;
  int   err_total = 0;
  int   res_cnt = 0;
  int   ce_at_frame = 0;
  int   frame_pair = 0;
  int   ready_mode = 0;
  bit   lat_check = 1'b0;
  exp_t exp_q[$];

  laststage_ctrl #(.IWIDTH(IW), .OWIDTH(OW), .LGSIZE(LG), .LATENCY(3)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
    .o_bf_ce(o_bf_ce), .o_bf_sync(o_bf_sync), .o_bf_left(o_bf_left), .o_bf_right(o_bf_right),
    .i_bf_left(bl3), .i_bf_right(br3),
    .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
    .m_first(m_first), .m_last(m_last), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Complex add (sub=0) or subtract (sub=1) of {re,im} samples, growing one bit.
  function automatic logic [2*OW-1:0] cplx(input logic [2*IW-1:0] a, input logic [2*IW-1:0] b,
                                           input bit sub);
    logic signed [OW-1:0] ar, ai, br, bi, yr, yi;
    ar = OW'($signed(a[2*IW-1:IW]));
    ai = OW'($signed(a[IW-1:0]));
    br = OW'($signed(b[2*IW-1:IW]));
    bi = OW'($signed(b[IW-1:0]));
    yr = sub ? (ar - br) : (ar + br);
    yi = sub ? (ai - bi) : (ai + bi);
    return {yr, yi};
  endfunction

  // Butterfly model: three enable-gated stages.
  always @(posedge clk) begin
    if (o_bf_ce) begin
      bl1 <= cplx(o_bf_left, o_bf_right, 1'b0);
      br1 <= cplx(o_bf_left, o_bf_right, 1'b1);
      bl2 <= bl1;
      br2 <= br1;
      bl3 <= bl2;
      br3 <= br2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Downstream ready: always high, or a fair coin each cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
    end
  end

  // Scoreboard and event counters, sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!i_reset) begin
      if (o_bf_ce) chk("ce_needs_ready", 64'(m_ready), 64'(1));
      if (m_valid && m_ready) begin
        chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_left", 64'(m_left), 64'(e.l));
          chk("m_right", 64'(m_right), 64'(e.r));
          chk("m_first", 64'(m_first), 64'(e.f));
          chk("m_last", 64'(m_last), 64'(e.la));
          if (e.f && lat_check) chk("first_latency_ce", 64'(ce_total - ce_at_frame), 64'(3));
          res_cnt++;
        end
      end
      if (o_bf_ce) ce_total++;
      if (o_bf_sync) sync_total++;
      if (o_err) err_total++;
    end
  end

  // Offer one sample; called and returns just after a rising edge.
  task automatic send(input logic [2*IW-1:0] d, input logic f, output int waited);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    waited  = 0;
    @(negedge clk);
    while (!s_ready && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 2000) chk("send_timeout", 64'(waited), 64'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic send_pairs(input int n, input bit start_frame);
    logic [2*IW-1:0] ev, od;
    int w;
    exp_t e;
    if (start_frame) frame_pair = 0;
    for (int k = 0; k < n; k++) begin
      ev = 32'($urandom);
      od = 32'($urandom);
      send(ev, start_frame && (k == 0), w);
      send(od, 1'b0, w);
      e.l  = cplx(ev, od, 1'b0);
      e.r  = cplx(ev, od, 1'b1);
      e.f  = (frame_pair == 0);
      e.la = (frame_pair == NP - 1);
      exp_q.push_back(e);
      frame_pair++;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !s_ready || m_valid) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_done", 64'(w < 500), 64'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic full_frame(input int mode, input string nm);
    int ce0, sy0, rs0;
    ready_mode  = mode;
    ce0         = ce_total;
    sy0         = sync_total;
    rs0         = res_cnt;
    ce_at_frame = ce_total;
    lat_check   = 1'b1;
    send_pairs(NP, 1'b1);
    drain();
    lat_check  = 1'b0;
    ready_mode = 0;
    chk({nm, "_result_count"}, 64'(res_cnt - rs0), 64'(NP));
    chk({nm, "_sync_count"}, 64'(sync_total - sy0), 64'(1));
    chk({nm, "_bubble_count"}, 64'(ce_total - ce0 - NP), 64'(3));
    chk({nm, "_idle_ready"}, 64'(s_ready), 64'(1));
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_s_ready"}, 64'(s_ready), 64'(1));
    chk({nm, "_bf_ce"}, 64'(o_bf_ce), 64'(0));
    chk({nm, "_bf_sync"}, 64'(o_bf_sync), 64'(0));
    chk({nm, "_bf_left"}, 64'(o_bf_left), 64'(0));
    chk({nm, "_bf_right"}, 64'(o_bf_right), 64'(0));
    chk({nm, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({nm, "_m_first"}, 64'(m_first), 64'(0));
    chk({nm, "_m_last"}, 64'(m_last), 64'(0));
    chk({nm, "_err"}, 64'(o_err), 64'(0));
  endtask

  initial begin
    int w, ce0, rs0, er0;
    i_reset = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk);
    #1;

    // Samples with no frame start are swallowed in idle.
    ce0 = ce_total;
    for (int i = 0; i < 6; i++) begin
      send(32'($urandom), 1'b0, w);
      chk("idle_accept_wait", 64'(w), 64'(0));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_ce", 64'(ce_total - ce0), 64'(0));
    chk("idle_no_result", 64'(res_cnt), 64'(0));

    full_frame(0, "fullrate");
    full_frame(1, "randready");

    // Reset in the middle of pair 100.
    send_pairs(100, 1'b1);
    send(32'($urandom), 1'b0, w);
    i_reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_valid", 64'(m_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    full_frame(0, "afterreset");

`ifdef LASTSTAGE_CTRL_FRAMECHECK_EN
    // Frame restart on sample 5: old pairs 0 and 1 drain, then a fresh frame.
    er0 = err_total;
    rs0 = res_cnt;
    send_pairs(2, 1'b1);
    send(32'($urandom), 1'b0, w);
    send_pairs(NP, 1'b1);
    drain();
    chk("resync_err_pulses", 64'(err_total - er0), 64'(1));
    chk("resync_result_count", 64'(res_cnt - rs0), 64'(NP + 2));
`else
    er0 = err_total;
    chk("err_never", 64'(er0), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
